// File: rtl/gauss_pkg.sv
// Shared widths, pipeline tag type and kernel arithmetic helpers for the
// 3x3 Gaussian blur stage.
package gauss_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned ROW_W        = 10;
  localparam int unsigned SUM_W        = 12;
  localparam int unsigned KERNEL_SHIFT = 4;
  localparam int unsigned ROUND        = 8;
  localparam int unsigned PIPE_DEPTH   = 3;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic valid;
    logic line_end;
    logic frame_end;
  } tag_t;

  function automatic row_t row_sum(input pix_t a, input pix_t b, input pix_t c);
    return row_t'(a) + (row_t'(b) << 1) + row_t'(c);
  endfunction

  function automatic pix_t kernel_norm(input sum_t s);
    sum_t r;
    r = s + sum_t'(ROUND);
    return pix_t'(r >> KERNEL_SHIFT);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store with a registered read; each location is rewritten
// one cycle after it was read, with forwarding when both hit the same index.
module line_buffer #(
  parameter int unsigned DEPTH  = 220,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/gaussian3x3_stream.sv
// 3x3 Gaussian blur on a raster pixel stream: raster counters with resync,
// two line buffers, a 3x3 window and a 3-stage valid-tagged adder pipeline.
module gaussian3x3_stream
  import gauss_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 220,
  parameter int unsigned IMG_HEIGHT = 168
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       line_end,
  input  logic       frame_end,
  output logic [7:0] g_pixel,
  output logic       g_valid,
  output logic       g_line_end,
  output logic       g_frame_end,
  output logic       sync_err
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Sideband always wins; a count reaching the line/frame limit without it
  // wraps on its own. Either disagreement latches sync_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      sync_err <= 1'b0;
    end else if (pixel_valid) begin
      if (frame_end) begin
        x_cnt <= '0;
        y_cnt <= '0;
        if ((x_cnt != X_LAST) || (y_cnt != Y_LAST)) sync_err <= 1'b1;
      end else if (line_end || (x_cnt == X_LAST)) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
        if ((x_cnt != X_LAST) || !line_end || (y_cnt == Y_LAST)) sync_err <= 1'b1;
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  // S1: line buffer read and capture of the incoming beat
  logic          beat1;
  tag_t          tag1;
  pix_t          pix1;
  logic [XW-1:0] x1;
  pix_t          lb0_q;
  pix_t          lb1_q;
  logic          window_ok;

  assign window_ok = pixel_valid && (x_cnt >= XW'(2)) && (y_cnt >= YW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat1 <= 1'b0;
      tag1  <= '0;
      pix1  <= '0;
      x1    <= '0;
    end else begin
      beat1 <= pixel_valid;
      tag1  <= window_ok ? '{valid: 1'b1,
                             line_end: (x_cnt == X_LAST),
                             frame_end: (x_cnt == X_LAST) && (y_cnt == Y_LAST)}
                         : '0;
      if (pixel_valid) begin
        pix1 <= pixel_in;
        x1   <= x_cnt;
      end
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W), .ADDR_W(XW)) u_lb0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (pixel_valid),
    .rd_addr (x_cnt),
    .wr_en   (beat1),
    .wr_addr (x1),
    .wr_data (pix1),
    .rd_data (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W), .ADDR_W(XW)) u_lb1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (pixel_valid),
    .rd_addr (x_cnt),
    .wr_en   (beat1),
    .wr_addr (x1),
    .wr_data (lb0_q),
    .rd_data (lb1_q)
  );

  // The newest window column is the S1 register set itself; only the two
  // older columns are held in shift registers, which keeps latency at 3.
  pix_t col  [3];
  pix_t win0 [3];
  pix_t win1 [3];

  always_comb begin
    col[0] = lb1_q;
    col[1] = lb0_q;
    col[2] = pix1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win0[r] <= '0;
        win1[r] <= '0;
      end
    end else if (beat1) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win0[r] <= win1[r];
        win1[r] <= col[r];
      end
    end
  end

  // S2: weighted row sums
  tag_t tag2;
  row_t rsum [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag2 <= '0;
      for (int unsigned r = 0; r < 3; r++) rsum[r] <= '0;
    end else begin
      tag2 <= tag1;
      if (tag1.valid) begin
        for (int unsigned r = 0; r < 3; r++) rsum[r] <= row_sum(win0[r], win1[r], col[r]);
      end
    end
  end

  // S3: column combine, round and normalise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_pixel     <= '0;
      g_valid     <= 1'b0;
      g_line_end  <= 1'b0;
      g_frame_end <= 1'b0;
    end else begin
      g_valid     <= tag2.valid;
      g_line_end  <= tag2.line_end;
      g_frame_end <= tag2.frame_end;
      if (tag2.valid) begin
        g_pixel <= kernel_norm(sum_t'(rsum[0]) + (sum_t'(rsum[1]) << 1) + sum_t'(rsum[2]));
      end
    end
  end

endmodule

// File: tb/tb_gaussian3x3_stream.sv
// Directed bench for gaussian3x3_stream (8x6 frames): a frame-array blur model
// predicts every output beat and its arrival cycle; literal checks pin the model.
module tb_gaussian3x3_stream;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       line_end;
  logic       frame_end;
  logic [7:0] g_pixel;
  logic       g_valid;
  logic       g_line_end;
  logic       g_frame_end;
  logic       sync_err;

  gaussian3x3_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .g_pixel     (g_pixel),
    .g_valid     (g_valid),
    .g_line_end  (g_line_end),
    .g_frame_end (g_frame_end),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          pix;
    int          le;
    int          fe;
  } exp_t;

  exp_t        exp_q [$];
  int          got   [$];
  int          img   [H][W];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          le_cnt = 0;
  int          fe_cnt = 0;
  int          fe_idx = -1;
  bit          chk_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Blur of the window whose bottom-right is (x,y), straight from the frame array
  function automatic int model(input int x, input int y);
    int s = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        s += ((dx == 1) ? 2 : 1) * ((dy == 1) ? 2 : 1) * img[y-2+dy][x-2+dx];
    return (s + 8) / 16;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;
      pixel_in    = 8'($urandom);
    end
  endtask

  task automatic beat(input int x, input int y, input bit le, input bit fe);
    exp_t e;
    @(posedge clk); #1;
    pixel_in    = 8'(img[y][x]);
    pixel_valid = 1'b1;
    line_end    = le;
    frame_end   = fe;
    if (chk_en && x >= 2 && y >= 2) begin
      e.cyc = cyc;
      e.pix = model(x, y);
      e.le  = (x == W-1) ? 1 : 0;
      e.fe  = (x == W-1 && y == H-1) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  // short_y: row ended early by line_end after 6 pixels; max_beats<0: whole frame
  task automatic send_frame(input int bub, input int short_y, input int max_beats);
    int n = 0;
    int wlen;
    for (int y = 0; y < H; y++) begin
      wlen = (y == short_y) ? 6 : W;
      for (int x = 0; x < wlen; x++) begin
        if (max_beats >= 0 && n == max_beats) return;
        while ($urandom_range(0, 99) < bub) idle(1);
        beat(x, y, x == wlen-1, (x == wlen-1) && (y == H-1));
        n++;
      end
    end
  endtask

  task automatic clear_capture();
    got.delete();
    le_cnt = 0;
    fe_cnt = 0;
    fe_idx = -1;
  endtask

  task automatic finish_frame(input string tag, input int n_beats, input int n_fe);
    idle(8);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_count"}, got.size(), n_beats);
    chk({tag, "_frame_ends"}, fe_cnt, n_fe);
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = x * 20 + y * 10;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (!rst_n) begin
      chk("reset_outputs", int'({g_valid, g_line_end, g_frame_end, sync_err, g_pixel}), 0);
    end else if (chk_en) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc + 3 == cyc);
      chk("g_valid", int'(g_valid), int'(due));
      if (due) begin
        e = exp_q.pop_front();
        if (g_valid) begin
          chk("g_pixel", int'(g_pixel), e.pix);
          chk("g_line_end", int'(g_line_end), e.le);
          chk("g_frame_end", int'(g_frame_end), e.fe);
        end
      end
      if (!g_valid) chk("idle_sideband", int'({g_line_end, g_frame_end}), 0);
      if (g_valid) begin
        if (g_frame_end) fe_idx = got.size();
        got.push_back(int'(g_pixel));
        le_cnt += int'(g_line_end);
        fe_cnt += int'(g_frame_end);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Constant frame
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 100;
    clear_capture();
    send_frame(0, -1, -1);
    finish_frame("const", 24, 1);
    chk("const_line_ends", le_cnt, 4);
    chk("const_fe_position", fe_idx, 23);
    chk("const_sync_err", int'(sync_err), 0);
    if (got.size() == 24)
      for (int i = 0; i < 24; i++) chk("const_pixel", got[i], 100);

    // Impulse at (3,3)
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 0;
    img[3][3] = 255;
    clear_capture();
    send_frame(0, -1, -1);
    finish_frame("impulse", 24, 1);
    if (got.size() == 24) begin
      chk("imp_centre", got[14], 64);
      chk("imp_left",   got[13], 32);
      chk("imp_right",  got[15], 32);
      chk("imp_up",     got[8],  32);
      chk("imp_down",   got[20], 32);
      chk("imp_diag_ul", got[7],  16);
      chk("imp_diag_ur", got[9],  16);
      chk("imp_diag_dl", got[19], 16);
      chk("imp_diag_dr", got[21], 16);
      chk("imp_far0",   got[0],  0);
      chk("imp_far23",  got[23], 0);
    end

    // Ramp with ~50% bubbles: a linear image blurs to its centre value
    fill_ramp();
    clear_capture();
    send_frame(50, -1, -1);
    finish_frame("ramp", 24, 1);
    chk("ramp_line_ends", le_cnt, 4);
    if (got.size() == 24) begin
      chk("ramp_first", got[0], 30);
      chk("ramp_last", got[23], 160);
    end

    // Back-to-back frames with no gap
    clear_capture();
    fill_random();
    send_frame(0, -1, -1);
    fill_random();
    send_frame(0, -1, -1);
    finish_frame("b2b", 48, 2);
    chk("b2b_sync_err", int'(sync_err), 0);

    // Early line_end on row 2, then a clean frame after resync
    chk_en = 1'b0;
    fill_random();
    send_frame(0, 2, -1);
    idle(8);
    chk("sync_err_set", int'(sync_err), 1);
    chk_en = 1'b1;
    clear_capture();
    fill_ramp();
    send_frame(0, -1, -1);
    finish_frame("resync", 24, 1);
    chk("resync_line_ends", le_cnt, 4);
    chk("sync_err_sticky", int'(sync_err), 1);

    // Reset mid-row 3, then a fresh frame
    fill_random();
    send_frame(0, -1, 28);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    pixel_valid = 1'b0;
    line_end    = 1'b0;
    frame_end   = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk("sync_err_cleared", int'(sync_err), 0);
    clear_capture();
    fill_random();
    send_frame(0, -1, -1);
    finish_frame("post_reset", 24, 1);
    chk("post_reset_line_ends", le_cnt, 4);
    chk("post_reset_sync_err", int'(sync_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
